algo_result_capture: RTL and testbench
======================================

# algo_result_capture

Avalon-ST sink terminating the 16-bit cluster-result stream leaving `algo_top_cl`. It captures whole packets into a two-bank ping-pong buffer and exposes them to the soft processor through an Avalon-MM slave. It never back-pressures the algorithm, because `algo_top_cl` does not honour ready. When no bank is free, it drops whole packets and counts the drops.

## Interface
Parameters:
- `DATA_W`, 16: stream word width.
- `DEPTH`, 256: words per bank; power of two; maximum packet length stored.
- `CNT_W`, 16: width of each saturating error counter.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `data_in_data`  in  DATA_W  stream word.
- `data_in_valid`  in  1  beat qualifier.
- `data_in_startofpacket`  in  1  first beat of packet.
- `data_in_endofpacket`  in  1  last beat of packet.
- `data_in_empty`  in  1  accepted but ignored; the whole word is always stored.
- `data_in_ready`  out  1  tied 1 after reset release.
- `avs_address`  in  10  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data; fixed read latency of 1.
- `irq`  out  1  high while any bank is full.

## Operation
- FSM states:
  - IDLE: waiting for SOP.
  - CAPTURE: writing the target bank.
  - DISCARD: dropping beats until EOP.
- A beat is a cycle with `data_in_valid`=1.
- IDLE + beat with SOP:
  - Target bank `wsel` empty → store at index 0, go to CAPTURE.
  - Target bank full → `drop_cnt`++, go to DISCARD.
- IDLE + beat without SOP: ignore the beat; `proto_cnt`++.
- CAPTURE + beat: store at index `wptr`; `wptr`++.
  - If `wptr`==DEPTH, do not store the beat, set the bank's `trunc` flag, and go to DISCARD.
- CAPTURE + beat with SOP (restart): `proto_cnt`++, and capture restarts at index 0 of the same bank.
- EOP beat in CAPTURE (stored):
  - Commit: `len[wsel]`←`wptr`+1, `full[wsel]`←1.
  - `wsel` toggles; return to IDLE.
- SOP+EOP on the same beat: a 1-word packet, len=1.
- EOP in DISCARD:
  - If the packet was truncated, commit it with len=DEPTH.
  - Otherwise, drop it.
  - Return to IDLE; `wsel` toggles only on commit.
- Avalon-MM register map (by `avs_address`):
  - 0 STATUS: [0] full0, [1] full1, [2] trunc0, [3] trunc1, [4] oldest full bank index, [5] FSM≠IDLE.
  - 1 LEN0: bank 0 length, 0..DEPTH.
  - 2 LEN1: bank 1 length, 0..DEPTH.
  - 3 CONTROL, write-only:
    - bit0 releases bank 0: clears full0, trunc0 and LEN0.
    - bit1 releases bank 1: clears full1, trunc1 and LEN1.
  - 4 ERR: [15:0] `drop_cnt`, [31:16] `proto_cnt`. Both counters saturate and are cleared by writing any value to address 4.
  - 512–767: bank 0 word [7:0].
  - 768–1023: bank 1 word [7:0].
  - Data reads are zero-extended to 32 bits.
  - Unmapped reads return 0.
- Releasing a bank that is not full has no effect.
- A release and a commit in the same cycle on different banks both take effect.
- A release of the bank being committed in the same cycle is ignored, and the commit wins.
- The "oldest" index is the bank that was committed earlier. When only one bank is full, it is that bank.

## Timing
- Reset values: `data_in_ready`=0 while `rst_n`=0, then 1 from the first clock after release.
  - `avs_readdata`=0, `irq`=0, all flags, lengths and counters 0, `wsel`=0, FSM IDLE.
- Reset asserted mid-packet: everything is cleared and the partial packet is lost. After release, beats before the next SOP are counted in `proto_cnt`.
- Commit latency: the EOP beat is sampled at edge N; `full`, `len` and `irq` are visible from edge N+1.
- Read latency: `avs_readdata` is valid in the cycle after `avs_read`. The buffer is synchronous-read RAM.
- A register read in the same cycle as a commit returns the pre-commit value.
- A write to CONTROL takes effect at the sampling edge. The next SOP may then target the released bank.
- Throughput: one beat per clock indefinitely, with no bubble required between packets.

## Structure
- Package `algo_capture_pkg` holds:
  - the register address constants;
  - the STATUS bit indices;
  - the FSM state enum (IDLE, CAPTURE, DISCARD).
- One sub-module, `capture_bank_ram`: simple dual-port RAM with one write port and one synchronous read port, 2×DEPTH×DATA_W, addressed by {bank, index}.

## Test plan
- Single 163-word packet with data 0x0010..0x00B2 → LEN0=163, full0=1, irq=1, address 512+5 reads 0x15.
- Three back-to-back packets with no release → banks 0 and 1 are committed, the third is dropped, ERR[15:0]=1. After releasing bank 0, a fourth packet lands in bank 0.
- A 300-word packet → LEN0=256, trunc0=1, and word 255 holds the 256th input value.
- Orphan beats before the first SOP, and a second SOP mid-packet → ERR[31:16]=4 for 3 orphans plus 1 restart. The stored packet begins at the restart word.
- A 1-word SOP+EOP packet, with a release of bank 1 issued in the same cycle it commits into bank 1 → LEN1=1, full1 stays 1.
- `rst_n` pulsed low mid-capture → STATUS=0, ERR=0, LEN0=0. The next full packet captures normally into bank 0.

Source files
------------

// File: rtl/algo_capture_pkg.sv
// Shared constants and types for the cluster-result capture block.
package algo_capture_pkg;

  localparam logic [9:0] ADDR_STATUS  = 10'd0;
  localparam logic [9:0] ADDR_LEN0    = 10'd1;
  localparam logic [9:0] ADDR_LEN1    = 10'd2;
  localparam logic [9:0] ADDR_CONTROL = 10'd3;
  localparam logic [9:0] ADDR_ERR     = 10'd4;

  localparam int ST_FULL0  = 0;
  localparam int ST_FULL1  = 1;
  localparam int ST_TRUNC0 = 2;
  localparam int ST_TRUNC1 = 3;
  localparam int ST_OLDEST = 4;
  localparam int ST_BUSY   = 5;

  typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} cap_state_t;

endpackage

// File: rtl/algo_result_capture_if.sv
// Avalon-ST result stream plus Avalon-MM register/buffer port of the capture block.
interface algo_result_capture_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] data_in_data;
  logic              data_in_valid;
  logic              data_in_startofpacket;
  logic              data_in_endofpacket;
  logic              data_in_empty;
  logic              data_in_ready;
  logic [9:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              irq;

  modport master (
    output data_in_data, data_in_valid, data_in_startofpacket, data_in_endofpacket,
           data_in_empty, avs_address, avs_read, avs_write, avs_writedata,
    input  data_in_ready, avs_readdata, irq
  );

  modport slave (
    input  data_in_data, data_in_valid, data_in_startofpacket, data_in_endofpacket,
           data_in_empty, avs_address, avs_read, avs_write, avs_writedata,
    output data_in_ready, avs_readdata, irq
  );
endinterface

// File: rtl/capture_bank_ram.sv
// Two packet banks in one simple dual-port RAM, addressed by {bank, index}.
module capture_bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(2*DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         re,
  input  logic [$clog2(2*DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]            rdata
);
  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/algo_result_capture.sv
// Ping-pong packet capture of the algo_top_cl result stream; never stalls the source,
// drops whole packets when no bank is free, and exposes banks over Avalon-MM.
module algo_result_capture
  import algo_capture_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  algo_result_capture_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  cap_state_t              state, nstate;
  logic [LW-1:0]           wptr, wptr_n;
  logic                    wsel, dtrunc, dtr_n, oldest, n_oldest, rdy;
  logic [1:0]              full, trunc, rel, nf;
  logic [1:0][LW-1:0]      len;
  logic [CNT_W-1:0]        drop_cnt, proto_cnt;
  logic                    we, commit, set_tr, drop_inc, proto_inc;
  logic [AW-1:0]           widx;
  logic [LW-1:0]           clen;
  logic                    ctrl_wr, err_clr, rd_ram;
  logic [31:0]             rd_val, rd_q;
  logic [DATA_W-1:0]       ram_q;

  wire unused_bits = ^{bus.data_in_empty, bus.avs_writedata[31:2]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nstate;

  always_comb begin
    nstate    = state;
    wptr_n    = wptr;
    dtr_n     = dtrunc;
    we        = 1'b0;
    widx      = '0;
    commit    = 1'b0;
    clen      = '0;
    set_tr    = 1'b0;
    drop_inc  = 1'b0;
    proto_inc = 1'b0;
    if (bus.data_in_valid) begin
      case (state)
        IDLE: begin
          if (!bus.data_in_startofpacket) proto_inc = 1'b1;
          else if (!full[wsel]) begin
            we     = 1'b1;
            wptr_n = LW'(1);
            if (bus.data_in_endofpacket) begin commit = 1'b1; clen = LW'(1); end
            else nstate = CAPTURE;
          end else begin
            drop_inc = 1'b1;
            dtr_n    = 1'b0;
            if (!bus.data_in_endofpacket) nstate = DISCARD;
          end
        end
        CAPTURE: begin
          if (bus.data_in_startofpacket) begin
            // restart overwrites the same bank from the beginning
            proto_inc = 1'b1;
            we        = 1'b1;
            wptr_n    = LW'(1);
            if (bus.data_in_endofpacket) begin commit = 1'b1; clen = LW'(1); nstate = IDLE; end
          end else if (wptr == LW'(DEPTH)) begin
            set_tr = 1'b1;
            if (bus.data_in_endofpacket) begin commit = 1'b1; clen = LW'(DEPTH); nstate = IDLE; end
            else begin dtr_n = 1'b1; nstate = DISCARD; end
          end else begin
            we     = 1'b1;
            widx   = wptr[AW-1:0];
            wptr_n = wptr + LW'(1);
            if (bus.data_in_endofpacket) begin commit = 1'b1; clen = wptr + LW'(1); nstate = IDLE; end
          end
        end
        DISCARD: begin
          if (bus.data_in_endofpacket) begin
            nstate = IDLE;
            if (dtrunc) begin commit = 1'b1; clen = LW'(DEPTH); end
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  assign ctrl_wr = bus.avs_write && (bus.avs_address == ADDR_CONTROL);
  assign err_clr = bus.avs_write && (bus.avs_address == ADDR_ERR);

  // a release aimed at the bank committing this cycle loses to the commit
  always_comb begin
    for (int i = 0; i < 2; i++)
      rel[i] = ctrl_wr && bus.avs_writedata[i] && full[i] && !(commit && (wsel == i[0]));
    nf = (full & ~rel) | (commit ? (wsel ? 2'b10 : 2'b01) : 2'b00);
    n_oldest = oldest;
    if (nf == 2'b01)                n_oldest = 1'b0;
    else if (nf == 2'b10)           n_oldest = 1'b1;
    else if (nf == 2'b11 && commit) n_oldest = ~wsel;
  end

  always_comb begin
    rd_val = '0;
    case (bus.avs_address)
      ADDR_STATUS: begin
        rd_val[ST_FULL0]  = full[0];
        rd_val[ST_FULL1]  = full[1];
        rd_val[ST_TRUNC0] = trunc[0];
        rd_val[ST_TRUNC1] = trunc[1];
        rd_val[ST_OLDEST] = oldest;
        rd_val[ST_BUSY]   = (state != IDLE);
      end
      ADDR_LEN0: rd_val[LW-1:0] = len[0];
      ADDR_LEN1: rd_val[LW-1:0] = len[1];
      ADDR_ERR: begin
        rd_val[CNT_W-1:0]  = drop_cnt;
        rd_val[16 +: CNT_W] = proto_cnt;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      wsel      <= 1'b0;
      dtrunc    <= 1'b0;
      full      <= '0;
      trunc     <= '0;
      len       <= '0;
      oldest    <= 1'b0;
      drop_cnt  <= '0;
      proto_cnt <= '0;
      rd_q      <= '0;
      rd_ram    <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      rdy    <= 1'b1;
      wptr   <= wptr_n;
      dtrunc <= dtr_n;
      full   <= nf;
      oldest <= n_oldest;
      if (commit) begin
        wsel      <= ~wsel;
        len[wsel] <= clen;
      end
      if (set_tr) trunc[wsel] <= 1'b1;
      for (int i = 0; i < 2; i++)
        if (rel[i]) begin
          trunc[i] <= 1'b0;
          len[i]   <= '0;
        end
      if (err_clr) begin
        drop_cnt  <= '0;
        proto_cnt <= '0;
      end else begin
        if (drop_inc && drop_cnt != '1)   drop_cnt  <= drop_cnt + 1'b1;
        if (proto_inc && proto_cnt != '1) proto_cnt <= proto_cnt + 1'b1;
      end
      rd_q   <= bus.avs_read ? rd_val : '0;
      rd_ram <= bus.avs_read && bus.avs_address[9];
    end
  end

  capture_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wsel, widx}),
    .wdata (bus.data_in_data),
    .re    (bus.avs_read && bus.avs_address[9]),
    .raddr (bus.avs_address[AW:0]),
    .rdata (ram_q)
  );

  assign bus.avs_readdata  = rd_ram ? 32'(ram_q) : rd_q;
  assign bus.data_in_ready = rdy;
  assign bus.irq           = |full;

endmodule

// File: tb/tb_algo_result_capture.sv
// Randomized packet-level bench for algo_result_capture with a bank/packet reference model.
module tb_algo_result_capture;
  import algo_capture_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  algo_result_capture_if #(.DATA_W(16)) bus();

  algo_result_capture #(.DATA_W(16), .DEPTH(256), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // packet-level model of the two banks
  bit          m_full[2];
  bit          m_trunc[2];
  int          m_len[2];
  int          m_wsel, m_oldest, m_drop, m_proto;
  logic [15:0] m_mem[2][256];
  logic [15:0] pkt[$];

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 0; m_trunc[b] = 0; m_len[b] = 0;
    end
    m_wsel = 0; m_oldest = 0; m_drop = 0; m_proto = 0;
  endfunction

  function automatic void model_orphan();
    if (m_proto < 65535) m_proto++;
  endfunction

  function automatic void model_packet();
    int w = m_wsel;
    int n;
    if (m_full[w]) begin
      if (m_drop < 65535) m_drop++;
      return;
    end
    n = (pkt.size() > 256) ? 256 : pkt.size();
    for (int i = 0; i < n; i++) m_mem[w][i] = pkt[i];
    m_len[w]   = n;
    m_trunc[w] = (pkt.size() > 256);
    m_full[w]  = 1;
    m_oldest   = m_full[1-w] ? 1 - w : w;
    m_wsel     = 1 - w;
  endfunction

  function automatic void model_release(input logic [1:0] m);
    for (int b = 0; b < 2; b++)
      if (m[b] && m_full[b]) begin
        m_full[b] = 0; m_trunc[b] = 0; m_len[b] = 0;
      end
    if (m_full[0] && !m_full[1]) m_oldest = 0;
    else if (!m_full[0] && m_full[1]) m_oldest = 1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s = '0;
    s[0] = m_full[0]; s[1] = m_full[1]; s[2] = m_trunc[0]; s[3] = m_trunc[1];
    s[4] = m_oldest[0];
    return s;
  endfunction

  function automatic logic [31:0] exp_err();
    return {m_proto[15:0], m_drop[15:0]};
  endfunction

  task automatic idle();
    @(negedge clk);
    bus.data_in_valid = 0; bus.data_in_startofpacket = 0; bus.data_in_endofpacket = 0;
  endtask

  task automatic beat(input logic [15:0] d, input bit s, input bit e);
    @(negedge clk);
    bus.data_in_valid = 1; bus.data_in_data = d;
    bus.data_in_startofpacket = s; bus.data_in_endofpacket = e;
    bus.data_in_empty = $urandom_range(0, 1);
  endtask

  task automatic send_pkt(input int n, input logic [15:0] base, input bit rnd, input bit keep);
    logic [15:0] w;
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      w = rnd ? 16'($urandom) : base + 16'(i);
      pkt.push_back(w);
      beat(w, i == 0, i == n - 1);
    end
    model_packet();
    if (!keep) idle();
  endtask

  task automatic avs_rd(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_read = 1;
    @(negedge clk);
    bus.avs_read = 0;
    d = bus.avs_readdata;
  endtask

  task automatic avs_wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1;
    @(negedge clk);
    bus.avs_write = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    bus.data_in_valid = 0; bus.data_in_startofpacket = 0; bus.data_in_endofpacket = 0;
    bus.avs_read = 0; bus.avs_write = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [9:0]  a[5] = '{ADDR_STATUS, ADDR_LEN0, ADDR_LEN1, ADDR_CONTROL, ADDR_ERR};
    @(negedge clk);
    n_tests++;
    if (bus.data_in_ready !== 1'b0 || bus.irq !== 1'b0 || bus.avs_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b irq=%b rdata=%h, want 0/0/0", bus.data_in_ready, bus.irq, bus.avs_readdata);
    end
    rst_n = 1;
    model_reset();
    @(negedge clk);
    n_tests++;
    if (bus.data_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b want 1", bus.data_in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      avs_rd(a[i], d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", a[i], d); end
    end
  endtask

  task automatic test_single_packet();
    logic [31:0] d;
    do_reset();
    send_pkt(163, 16'h0010, 0, 1);
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_commit: got %b want 0", bus.irq); end
    idle();
    n_tests++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_commit: got %b want 1", bus.irq); end
    avs_rd(ADDR_LEN0, d);
    n_tests++;
    if (d !== 32'd163) begin n_fail++; $display("FAIL single_len0: got %0d want 163", d); end
    avs_rd(ADDR_STATUS, d);
    n_tests++;
    if (d !== exp_status() || d !== 32'h1) begin n_fail++; $display("FAIL single_status: got %h want %h", d, exp_status()); end
    avs_rd(10'd517, d);
    n_tests++;
    if (d !== 32'h15) begin n_fail++; $display("FAIL single_word5: got %h want 15", d); end
    avs_rd(10'd7, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          idx;
    do_reset();
    send_pkt($urandom_range(2, 40), 0, 1, 1);
    send_pkt($urandom_range(2, 40), 0, 1, 1);
    send_pkt($urandom_range(1, 40), 0, 1, 0);
    avs_rd(ADDR_STATUS, d);
    n_tests++;
    if (d !== exp_status() || d !== 32'h3) begin n_fail++; $display("FAIL b2b_status: got %h want %h", d, exp_status()); end
    avs_rd(ADDR_ERR, d);
    n_tests++;
    if (d !== exp_err() || d[15:0] !== 16'd1) begin n_fail++; $display("FAIL b2b_err: got %h want %h", d, exp_err()); end
    avs_rd(ADDR_LEN1, d);
    n_tests++;
    if (d !== 32'(m_len[1])) begin n_fail++; $display("FAIL b2b_len1: got %0d want %0d", d, m_len[1]); end
    avs_wr(ADDR_CONTROL, 32'h1);
    model_release(2'b01);
    avs_rd(ADDR_STATUS, d);
    n_tests++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL b2b_release_status: got %h want %h", d, exp_status()); end
    send_pkt($urandom_range(2, 40), 0, 1, 0);
    avs_rd(ADDR_STATUS, d);
    n_tests++;
    if (d !== exp_status() || d !== 32'h13) begin n_fail++; $display("FAIL b2b_fourth_status: got %h want %h", d, exp_status()); end
    avs_rd(ADDR_LEN0, d);
    n_tests++;
    if (d !== 32'(m_len[0])) begin n_fail++; $display("FAIL b2b_fourth_len0: got %0d want %0d", d, m_len[0]); end
    idx = $urandom_range(0, m_len[0] - 1);
    avs_rd(10'(512 + idx), d);
    n_tests++;
    if (d !== {16'h0, m_mem[0][idx]}) begin n_fail++; $display("FAIL b2b_fourth_word%0d: got %h want %h", idx, d, m_mem[0][idx]); end
    avs_wr(ADDR_ERR, 32'($urandom));
    m_drop = 0; m_proto = 0;
    avs_rd(ADDR_ERR, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL err_clear: got %h want 0", d); end
  endtask

  task automatic test_truncation();
    logic [31:0] d;
    do_reset();
    send_pkt(300, 0, 1, 0);
    avs_rd(ADDR_LEN0, d);
    n_tests++;
    if (d !== 32'd256) begin n_fail++; $display("FAIL trunc_len0: got %0d want 256", d); end
    avs_rd(ADDR_STATUS, d);
    n_tests++;
    if (d !== exp_status() || d !== 32'h5) begin n_fail++; $display("FAIL trunc_status: got %h want %h", d, exp_status()); end
    avs_rd(10'd767, d);
    n_tests++;
    if (d !== {16'h0, pkt[255]}) begin n_fail++; $display("FAIL trunc_word255: got %h want %h", d, pkt[255]); end
    avs_rd(10'd512, d);
    n_tests++;
    if (d !== {16'h0, pkt[0]}) begin n_fail++; $display("FAIL trunc_word0: got %h want %h", d, pkt[0]); end
  endtask

  task automatic test_protocol();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      beat(16'($urandom), 0, 0);
      model_orphan();
    end
    beat(16'h0BAD, 1, 0);
    beat(16'h0BAE, 0, 0);
    model_orphan();
    send_pkt(5, 16'h0A00, 0, 0);
    avs_rd(ADDR_ERR, d);
    n_tests++;
    if (d !== exp_err() || d !== 32'h0004_0000) begin n_fail++; $display("FAIL proto_err: got %h want %h", d, exp_err()); end
    avs_rd(ADDR_LEN0, d);
    n_tests++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL proto_len0: got %0d want 5", d); end
    avs_rd(10'd512, d);
    n_tests++;
    if (d !== 32'h0A00) begin n_fail++; $display("FAIL proto_word0: got %h want 0a00", d); end
  endtask

  task automatic test_one_word_release();
    logic [31:0] d;
    logic [15:0] w;
    do_reset();
    send_pkt(3, 0, 1, 0);
    w = 16'($urandom);
    @(negedge clk);
    bus.data_in_valid = 1; bus.data_in_data = w;
    bus.data_in_startofpacket = 1; bus.data_in_endofpacket = 1;
    bus.avs_address = ADDR_CONTROL; bus.avs_writedata = 32'h3; bus.avs_write = 1;
    @(negedge clk);
    bus.data_in_valid = 0; bus.data_in_startofpacket = 0; bus.data_in_endofpacket = 0;
    bus.avs_write = 0;
    pkt.delete(); pkt.push_back(w);
    model_packet();
    model_release(2'b01);
    avs_rd(ADDR_STATUS, d);
    n_tests++;
    if (d !== exp_status() || d !== 32'h12) begin n_fail++; $display("FAIL oneword_status: got %h want %h", d, exp_status()); end
    avs_rd(ADDR_LEN1, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL oneword_len1: got %0d want 1", d); end
    avs_rd(ADDR_LEN0, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL oneword_len0: got %0d want 0", d); end
    avs_rd(10'd768, d);
    n_tests++;
    if (d !== {16'h0, w}) begin n_fail++; $display("FAIL oneword_data: got %h want %h", d, w); end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] d;
    logic [31:0] got[3];
    do_reset();
    beat(16'h1111, 0, 0);
    beat(16'h2222, 1, 0);
    for (int i = 0; i < 5; i++) beat(16'($urandom), 0, 0);
    @(negedge clk);
    rst_n = 0;
    bus.data_in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    avs_rd(ADDR_STATUS, got[0]);
    avs_rd(ADDR_ERR, got[1]);
    avs_rd(ADDR_LEN0, got[2]);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (got[i] !== 32'h0) begin n_fail++; $display("FAIL midreset_reg%0d: got %h want 0", i, got[i]); end
    end
    beat(16'h3333, 0, 0);
    model_orphan();
    send_pkt(8, 0, 1, 0);
    avs_rd(ADDR_ERR, d);
    n_tests++;
    if (d !== exp_err() || d !== 32'h0001_0000) begin n_fail++; $display("FAIL midreset_orphan: got %h want %h", d, exp_err()); end
    avs_rd(ADDR_LEN0, d);
    n_tests++;
    if (d !== 32'd8) begin n_fail++; $display("FAIL midreset_len0: got %0d want 8", d); end
    avs_rd(10'd515, d);
    n_tests++;
    if (d !== {16'h0, pkt[3]}) begin n_fail++; $display("FAIL midreset_word3: got %h want %h", d, pkt[3]); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [9:0]  a[4] = '{ADDR_STATUS, ADDR_LEN0, ADDR_LEN1, ADDR_ERR};
    logic [31:0] e[4];
    bit          keep;
    int          len, idx;
    do_reset();
    for (int it = 0; it < 14; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)) - 1; k++) begin
        beat(16'($urandom), 0, 0);
        model_orphan();
      end
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 300) : $urandom_range(1, 60);
      keep = (it < 13) && ($urandom_range(0, 1) == 1);
      send_pkt(len, 0, 1, keep);
      if (!keep) begin
        e[0] = exp_status(); e[1] = 32'(m_len[0]); e[2] = 32'(m_len[1]); e[3] = exp_err();
        for (int i = 0; i < 4; i++) begin
          avs_rd(a[i], d);
          n_tests++;
          if (d !== e[i]) begin n_fail++; $display("FAIL rand%0d_reg%0d: got %h want %h", it, a[i], d, e[i]); end
        end
        n_tests++;
        if (bus.irq !== (m_full[0] | m_full[1])) begin n_fail++; $display("FAIL rand%0d_irq: got %b want %b", it, bus.irq, m_full[0] | m_full[1]); end
        for (int b = 0; b < 2; b++)
          if (m_full[b]) begin
            idx = $urandom_range(0, m_len[b] - 1);
            avs_rd(10'(512 + 256 * b + idx), d);
            n_tests++;
            if (d !== {16'h0, m_mem[b][idx]}) begin n_fail++; $display("FAIL rand%0d_bank%0d_word%0d: got %h want %h", it, b, idx, d, m_mem[b][idx]); end
          end
        if ($urandom_range(0, 2) != 0) begin
          d = 32'($urandom_range(0, 3));
          avs_wr(ADDR_CONTROL, d);
          model_release(d[1:0]);
        end
      end
    end
  endtask

  initial begin
    bus.data_in_data = '0; bus.data_in_valid = 0; bus.data_in_startofpacket = 0;
    bus.data_in_endofpacket = 0; bus.data_in_empty = 0;
    bus.avs_address = '0; bus.avs_read = 0; bus.avs_write = 0; bus.avs_writedata = '0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_truncation();
    test_protocol();
    test_one_word_release();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
